// File: rtl/serial_subtractor_if.sv
// Start/busy/done bus for the bit-serial subtractor.
// The controller drives start/a/b/bin and the subtractor drives busy/done/diff/bout/state.
// start is sampled only while state is IDLE. Once done is high, diff and bout are valid and stay valid until the next done pulse.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic [1:0]       state;

  modport master (output start, a, b, bin,
                  input  busy, done, diff, bout, state);
  modport slave  (input  start, a, b, bin,
                  output busy, done, diff, bout, state);
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock.
// One full-subtractor cell and one borrow flop do all of the arithmetic.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    count;
  logic             d;
  logic             br_next;

  always_comb begin
    d       = a_sr[0] ^ b_sr[0] ^ br;
    br_next = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  end

  assign bus.state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      res      <= '0;
      br       <= 1'b0;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.diff <= '0;
      bus.bout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr     <= bus.a;
            b_sr     <= bus.b;
            br       <= bus.bin;
            count    <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= {d, res[WIDTH-1:1]};
          br   <= br_next;
          // The last bit lands straight in diff, so the result is published on this same edge.
          if (count == CW'(WIDTH - 1)) begin
            bus.diff <= {d, res[WIDTH-1:1]};
            bus.bout <= br_next;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
